// File: rtl/clock_stepper.sv
// clock_stepper: debounced manual or periodic auto single-stepping of a processor clock.
module clock_stepper #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int AUTO_PERIOD     = 12500000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        KeyN,
  input  logic        AutoEn,
  input  logic [1:0]  Rate,
  input  logic        Halt,
  output logic        ProcClk,
  output logic        StepPulse,
  output logic        KeyState,
  output logic [15:0] StepCount
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(AUTO_PERIOD * 8);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t        state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [DW-1:0] deb_q, deb_d;
  logic          key_q, key_d, key_prev_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d, term;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          proc_clk_q, proc_clk_d, step_pulse_q, step_pulse_d;
  logic [15:0]   step_cnt_q, step_cnt_d;
  logic          raw, deb_full, press, tick, trig, go, pdone;
  always_comb begin
    sync_d       = {sync_q[0], KeyN};
    raw          = ~sync_q[1];
    deb_full     = deb_q == DW'(DEBOUNCE_CYCLES);
    deb_d        = (raw == key_q || deb_full) ? '0 : deb_q + DW'(1);
    key_d        = (raw != key_q && deb_full) ? raw : key_q;
    press        = key_q & ~key_prev_q;
    term         = TW'((AUTO_PERIOD << Rate) - 1);
    tick         = AutoEn && tick_cnt_q == term;
    tick_cnt_d   = (!AutoEn || tick) ? '0 : tick_cnt_q + TW'(1);
    trig         = AutoEn ? tick : press;
    go           = state_q == IDLE && trig && !Halt;
    pdone        = pcnt_q == PW'(PULSE_CYCLES - 1);
    state_d      = (state_q == IDLE) ? (go ? HIGH : IDLE) :
                   (state_q == HIGH) ? (pdone ? LOW : HIGH) :
                   (state_q == LOW && !pdone) ? LOW : IDLE;
    pcnt_d       = (state_q == IDLE || pdone) ? '0 : pcnt_q + PW'(1);
    proc_clk_d   = state_d == HIGH;
    step_pulse_d = go;
    step_cnt_d   = step_cnt_q + 16'(go);
  end
  // Synchronizer resets to "released" so a key held through reset debounces as a fresh press
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync_q       <= 2'b11;
      deb_q        <= '0;
      key_q        <= 1'b0;
      key_prev_q   <= 1'b0;
      tick_cnt_q   <= '0;
      state_q      <= IDLE;
      pcnt_q       <= '0;
      proc_clk_q   <= 1'b0;
      step_pulse_q <= 1'b0;
      step_cnt_q   <= '0;
    end else begin
      sync_q       <= sync_d;
      deb_q        <= deb_d;
      key_q        <= key_d;
      key_prev_q   <= key_q;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      pcnt_q       <= pcnt_d;
      proc_clk_q   <= proc_clk_d;
      step_pulse_q <= step_pulse_d;
      step_cnt_q   <= step_cnt_d;
    end
  end
  assign ProcClk   = proc_clk_q;
  assign StepPulse = step_pulse_q;
  assign KeyState  = key_q;
  assign StepCount = step_cnt_q;
endmodule

// File: tb/tb_clock_stepper.sv
// tb_clock_stepper: directed and randomized checks of clock_stepper against a timing model.
module tb_clock_stepper;
  localparam int DEB = 4, PUL = 2, AP = 8;
  logic Clock = 0, Resetn = 0, KeyN = 1, AutoEn = 0, Halt = 0;
  logic [1:0] Rate = 0;
  logic ProcClk, StepPulse, KeyState;
  logic [15:0] StepCount;
  int checks = 0, failures = 0;
  logic [15:0] exp_cnt = 0;
  int lows[$];
  clock_stepper #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL), .AUTO_PERIOD(AP)) dut (
    .Clock(Clock), .Resetn(Resetn), .KeyN(KeyN), .AutoEn(AutoEn), .Rate(Rate), .Halt(Halt),
    .ProcClk(ProcClk), .StepPulse(StepPulse), .KeyState(KeyState), .StepCount(StepCount)
  );
  always #5 Clock = ~Clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset(input logic k);
    Resetn = 0; AutoEn = 0; Halt = 0; Rate = 0; KeyN = k;
    repeat (2) @(negedge Clock);
    chk("rst_procclk", 32'(ProcClk), 0);
    chk("rst_pulse", 32'(StepPulse), 0);
    chk("rst_keystate", 32'(KeyState), 0);
    chk("rst_count", 32'(StepCount), 0);
    Resetn = 1;
    exp_cnt = 0;
  endtask
  // Key drive: each entry of lows is a short low burst followed by one high cycle, then a stable press.
  // Stable press starting before edge f: KeyState after edge f+DEB+2, step HIGH from edge f+DEB+3.
  task automatic manual_step(input logic h, input string tag);
    logic lv[$];
    int f, s;
    foreach (lows[i]) begin
      repeat (lows[i]) lv.push_back(1'b0);
      lv.push_back(1'b1);
    end
    f = lv.size();
    s = f + DEB + 3;
    repeat (DEB + 2 * PUL + 6) lv.push_back(1'b0);
    Halt = h;
    foreach (lv[e]) begin
      KeyN = lv[e];
      @(negedge Clock);
      if (!h && e == s) exp_cnt++;
      chk($sformatf("%s_ks@%0d", tag, e), 32'(KeyState), 32'(e >= f + DEB + 2));
      chk($sformatf("%s_clk@%0d", tag, e), 32'(ProcClk), 32'(!h && e >= s && e < s + PUL));
      chk($sformatf("%s_pulse@%0d", tag, e), 32'(StepPulse), 32'(!h && e == s));
      chk($sformatf("%s_cnt@%0d", tag, e), 32'(StepCount), 32'(exp_cnt));
    end
    KeyN = 1;
    repeat (DEB + 8) @(negedge Clock);
    chk({tag, "_rel_ks"}, 32'(KeyState), 0);
    chk({tag, "_rel_clk"}, 32'(ProcClk), 0);
    chk({tag, "_rel_cnt"}, 32'(StepCount), 32'(exp_cnt));
    Halt = 0;
  endtask
  // Auto mode from a held-zero counter: ticks consumed at edges p-1, 2p-1, ...
  task automatic auto_run(input logic [1:0] r, input int len, input int hmode, input string tag);
    int p, busy_end, hs;
    logic h, st;
    p = AP << r; busy_end = 0; hs = -100;
    Rate = r;
    for (int e = 0; e < len; e++) begin
      h = (hmode == 1) ? ($urandom_range(0, 3) == 0) : (hmode == 2 && e >= 8 && e < 30);
      AutoEn = 1; Halt = h;
      @(negedge Clock);
      st = ((e + 1) % p == 0) && !h && e >= busy_end;
      if (st) begin hs = e; busy_end = e + 2 * PUL + 1; exp_cnt++; end
      chk($sformatf("%s_clk@%0d", tag, e), 32'(ProcClk), 32'(e >= hs && e < hs + PUL));
      chk($sformatf("%s_pulse@%0d", tag, e), 32'(StepPulse), 32'(st));
      chk($sformatf("%s_cnt@%0d", tag, e), 32'(StepCount), 32'(exp_cnt));
    end
    AutoEn = 0; Halt = 0;
    repeat (2 * PUL + 2) @(negedge Clock);
    chk({tag, "_end_clk"}, 32'(ProcClk), 0);
    chk({tag, "_end_cnt"}, 32'(StepCount), 32'(exp_cnt));
  endtask
  initial begin
    int n, found;
    do_reset(1'b1);
    lows = {}; manual_step(1'b0, "clean");
    chk("clean_total", 32'(StepCount), 1);
    lows = {3}; manual_step(1'b0, "bounce");
    chk("bounce_total", 32'(StepCount), 2);
    repeat (3) begin
      lows = {};
      n = $urandom_range(1, 3);
      repeat (n) lows.push_back($urandom_range(1, DEB));
      manual_step(1'b0, "rand_bounce");
    end
    lows = {}; manual_step(1'b1, "halt_press");
    chk("halt_press_total", 32'(StepCount), 5);
    do_reset(1'b1);
    auto_run(2'd0, 40, 0, "auto_r0");
    chk("auto_r0_total", 32'(StepCount), 5);
    auto_run(2'd1, 32, 0, "auto_r1");
    chk("auto_r1_total", 32'(StepCount), 7);
    auto_run(2'd0, 48, 2, "auto_halt");
    chk("auto_halt_total", 32'(StepCount), 11);
    repeat (6) auto_run(2'($urandom_range(0, 3)), $urandom_range(40, 160), 1, "auto_rand");
    dut.step_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    @(negedge Clock);
    chk("wrap_preload", 32'(StepCount), 32'hFFFE);
    auto_run(2'd0, 16, 0, "wrap");
    chk("wrap_total", 32'(StepCount), 0);
    Rate = 0; AutoEn = 1; found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge Clock);
      if (ProcClk) found = 1;
    end
    chk("mid_high_seen", 32'(found), 1);
    #2 Resetn = 0;
    #1;
    chk("async_procclk", 32'(ProcClk), 0);
    chk("async_pulse", 32'(StepPulse), 0);
    chk("async_keystate", 32'(KeyState), 0);
    chk("async_count", 32'(StepCount), 0);
    do_reset(1'b0);
    lows = {}; manual_step(1'b0, "held");
    chk("held_total", 32'(StepCount), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_stepper.md
CLOCK_STEPPER -- requirements
Module: clock_stepper

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive cycles the synchronized key must differ from its stable value before that value updates (20 ms at 50 MHz).
REQ-002 Parameter PULSE_CYCLES, default 4, is the number of cycles ProcClk is held high, and then held low, per step.
REQ-003 Parameter AUTO_PERIOD, default 12500000, is the base auto-step period in cycles, and SHALL be >= 2*PULSE_CYCLES.
REQ-004 Port Clock, input, width 1, is the board system clock; it is the only clock.
REQ-005 Port Resetn, input, width 1, is an asynchronous, active-low reset.
REQ-006 Port KeyN, input, width 1, is the raw pushbutton: active-low, asynchronous, bouncing.
REQ-007 Port AutoEn, input, width 1, selects mode: 1 = auto-step, 0 = manual-step from the key.
REQ-008 Port Rate, input, width 2, selects the auto period: AUTO_PERIOD shifted left by Rate (x1, x2, x4, x8).
REQ-009 Port Halt, input, width 1, blocks the start of new steps while it is 1.
REQ-010 Port ProcClk, output, width 1, is the step clock fed to the processor's Clock input.
REQ-011 Port StepPulse, output, width 1, is a one-cycle strobe marking each ProcClk rising edge.
REQ-012 Port KeyState, output, width 1, is the debounced key level (1 = pressed), for a status LED.
REQ-013 Port StepCount, output, width 16, is the number of steps issued since reset.

Function
REQ-014 KeyN SHALL pass through a two-flop synchronizer; the internal raw key level is the inverted second flop.
REQ-015 The debounce counter SHALL clear whenever raw equals KeyState, and increment while raw differs.
REQ-016 On the cycle the raw key has differed from KeyState for DEBOUNCE_CYCLES consecutive cycles, KeyState SHALL load raw and the counter SHALL clear; any bounce before then restarts the count.
REQ-017 A press trigger SHALL be a one-cycle strobe asserted in the first cycle KeyState is 1 after being 0; a release produces no trigger.
REQ-018 With AutoEn=1, a tick counter SHALL run and emit a one-cycle tick at terminal count (AUTO_PERIOD<<Rate)-1, then wrap to 0.
REQ-019 With AutoEn=0, the tick counter SHALL be held at 0; a Rate change in auto mode takes effect at the next terminal-count compare.
REQ-020 The active trigger SHALL be the press trigger when AutoEn=0 and the tick when AutoEn=1; the inactive source is ignored.
REQ-021 The FSM SHALL have the states IDLE, HIGH and LOW.
REQ-022 In IDLE, an active trigger with Halt=0 SHALL move the FSM to HIGH on the next edge; with Halt=1 the trigger is discarded, not queued.
REQ-023 The FSM SHALL stay in HIGH for exactly PULSE_CYCLES cycles, then in LOW for exactly PULSE_CYCLES cycles, then return to IDLE.
REQ-024 ProcClk SHALL be a registered output equal to 1 only in HIGH, so that it is glitch-free.
REQ-025 Triggers arriving in HIGH or LOW SHALL be dropped.
REQ-026 Halt asserted in HIGH or LOW SHALL NOT shorten the step in progress.
REQ-027 StepPulse SHALL be 1 only in the first cycle of HIGH.
REQ-028 StepCount SHALL increment by 1 on each entry into HIGH, wrapping from 0xFFFF to 0x0000.
REQ-029 Manual-step latency SHALL be: with KeyN falling cleanly before edge 0, ProcClk is 1 after edge DEBOUNCE_CYCLES+3.
REQ-030 Auto-step latency SHALL be: ProcClk is 1 one edge after the tick.

Reset
REQ-031 Resetn=0 SHALL immediately force ProcClk=0, StepPulse=0, KeyState=0, StepCount=0, all counters to 0, both synchronizer flops to 1 (key released), and the FSM to IDLE.
REQ-032 Reset asserted during HIGH SHALL drop ProcClk asynchronously, with no completion of the step.
REQ-033 After Resetn deasserts, a key held down SHALL be treated as a new press once debounced.

Verification (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2, AUTO_PERIOD=8)
REQ-034 Clean press: KeyN 1->0 before edge 0 -> KeyState=1 after edge 6, ProcClk=1 after edges 7-8, ProcClk=0 after edges 9-10, StepCount=1, exactly one StepPulse.
REQ-035 Bounce: KeyN low 3 cycles, high 1 cycle, then low -> no step until 4 consecutive synchronized low cycles; exactly one step, StepCount=1.
REQ-036 Auto mode: AutoEn=1, Rate=00, held 40 cycles -> 5 ticks, 5 steps with ProcClk high 2 cycles each; with Rate=01 -> period 16, StepCount +2 per 32 cycles.
REQ-037 Halt: AutoEn=1, Halt=1 asserted mid-HIGH -> the current step completes and StepCount stops increasing; Halt=0 -> steps resume at the next tick.
REQ-038 Wrap/reset: preload via 65535 auto steps, one more step -> StepCount=0x0000; Resetn pulsed low mid-HIGH -> ProcClk=0 in the same cycle and all outputs 0.
